// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_stage_if;
    logic        DmemReq;
    logic        DmemWe;
    logic [31:0] DmemAddr;
    logic [31:0] DmemWdata;
    logic [3:0]  DmemBe;
    logic [31:0] DmemRdata;
    logic        DmemAck;

    modport master (
        output DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
        input  DmemRdata, DmemAck
    );

    modport slave (
        input  DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
        output DmemRdata, DmemAck
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores over a req/ack bus.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ExValid_i,
    input  logic [31:0]       ExAluResult_i,
    input  logic [31:0]       ExStoreData_i,
    input  logic              ExMemRead_i,
    input  logic              ExMemWrite_i,
    input  logic [2:0]        ExFunct3_i,
    input  logic              ExRegWrite_i,
    input  logic [4:0]        ExRd_i,
    output logic              MemStall_o,
    mem_stage_if.master       dmem,
    output logic [31:0]       MemResult_o,
    output logic              MemRegWrite_o,
    output logic [4:0]        MemRd_o,
    output logic              MemMisalign_o
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              MemTimeout_o
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [31:0] res_q, res_d;
    logic        rw_q, rw_d;
    logic [4:0]  rd_q, rd_d;
    logic        mis_q, mis_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    // Attributes of the outstanding access, captured when it is issued.
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        ld_q, ld_d;
    logic        rwl_q, rwl_d;
    logic [4:0]  rdl_q, rdl_d;
`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  cnt_q, cnt_d;
    logic        to_q, to_d;
`endif

    logic        memop, aligned;
    logic [1:0]  off;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        stall;

    assign memop = ExValid_i & (ExMemRead_i | ExMemWrite_i);
    assign off   = ExAluResult_i[1:0];

    // funct3[1:0] gives the size (00 B, 01 H, else W); funct3[2] selects zero extension.
    always_comb begin
        aligned   = 1'b1;
        be_new    = 4'b1111;
        wdata_new = ExStoreData_i;
        case (ExFunct3_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << off;
                wdata_new = {4{ExStoreData_i[7:0]}};
            end
            2'b01: begin
                aligned   = ~off[0];
                be_new    = 4'b0011 << off;
                wdata_new = {2{ExStoreData_i[15:0]}};
            end
            default: aligned = (off == 2'b00);
        endcase
    end

    assign ld_byte = 8'(dmem.DmemRdata >> {off_q, 3'b000});
    assign ld_half = off_q[1] ? dmem.DmemRdata[31:16] : dmem.DmemRdata[15:0];

    always_comb begin
        case (f3_q[1:0])
            2'b00:   ld_data = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
            default: ld_data = dmem.DmemRdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rw_d    = rw_q;
        rd_d    = rd_q;
        mis_d   = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        off_d   = off_q;
        f3_d    = f3_q;
        ld_d    = ld_q;
        rwl_d   = rwl_q;
        rdl_d   = rdl_q;
        stall   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (memop && !aligned) begin
                    rw_d  = 1'b0;
                    mis_d = 1'b1;
                end else if (memop) begin
                    stall   = 1'b1;
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = ~ExMemRead_i;
                    addr_d  = {ExAluResult_i[31:2], 2'b00};
                    wdata_d = wdata_new;
                    be_d    = be_new;
                    off_d   = off;
                    f3_d    = ExFunct3_i;
                    ld_d    = ExMemRead_i;
                    rwl_d   = ExRegWrite_i;
                    rdl_d   = ExRd_i;
                    rw_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else begin
                    res_d = ExAluResult_i;
                    rw_d  = ExValid_i & ExRegWrite_i;
                    rd_d  = ExRd_i;
                end
            end
            ACCESS: begin
                rw_d = 1'b0;
                if (dmem.DmemAck) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (ld_q) begin
                        res_d = ld_data;
                        rw_d  = rwl_q;
                        rd_d  = rdl_q;
                    end
                end else begin
                    stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    // Abort releases the pipeline in the same cycle; the instruction is dropped.
                    if (cnt_q == TO_LAST) begin
                        stall   = 1'b0;
                        state_d = IDLE;
                        req_d   = 1'b0;
                        to_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            rw_q    <= 1'b0;
            rd_q    <= '0;
            mis_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            ld_q    <= 1'b0;
            rwl_q   <= 1'b0;
            rdl_q   <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rw_q    <= rw_d;
            rd_q    <= rd_d;
            mis_q   <= mis_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            ld_q    <= ld_d;
            rwl_q   <= rwl_d;
            rdl_q   <= rdl_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign MemStall_o     = stall;
    assign dmem.DmemReq   = req_q;
    assign dmem.DmemWe    = we_q;
    assign dmem.DmemAddr  = addr_q;
    assign dmem.DmemWdata = wdata_q;
    assign dmem.DmemBe    = be_q;
    assign MemResult_o    = res_q;
    assign MemRegWrite_o  = rw_q;
    assign MemRd_o        = rd_q;
    assign MemMisalign_o  = mis_q;
`ifdef MEM_TIMEOUT_EN
    assign MemTimeout_o   = to_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through/misalign vector table plus load, store and reset sequences.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ExValid, ExMemRead, ExMemWrite, ExRegWrite;
    logic [31:0] ExAluResult, ExStoreData;
    logic [2:0]  ExFunct3;
    logic [4:0]  ExRd;
    logic        MemStall, MemRegWrite, MemMisalign;
    logic [31:0] MemResult;
    logic [4:0]  MemRd;
`ifdef MEM_TIMEOUT_EN
    logic        MemTimeout;
`endif
    int vec_n = 0;
    int miss_n = 0;

    mem_stage_if dm ();

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ExValid_i(ExValid), .ExAluResult_i(ExAluResult), .ExStoreData_i(ExStoreData),
        .ExMemRead_i(ExMemRead), .ExMemWrite_i(ExMemWrite), .ExFunct3_i(ExFunct3),
        .ExRegWrite_i(ExRegWrite), .ExRd_i(ExRd),
        .MemStall_o(MemStall), .dmem(dm),
        .MemResult_o(MemResult), .MemRegWrite_o(MemRegWrite), .MemRd_o(MemRd),
        .MemMisalign_o(MemMisalign)
`ifdef MEM_TIMEOUT_EN
        , .MemTimeout_o(MemTimeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                          input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic rw, input logic [4:0] rd);
        ExValid = v; ExAluResult = alu; ExStoreData = sd; ExMemRead = rd_en;
        ExMemWrite = wr_en; ExFunct3 = f3; ExRegWrite = rw; ExRd = rd;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
    endtask

    // Load issued at posedge+1; memory acks after 'waits' wait cycles.
    task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] word, input int waits,
                           input logic [31:0] exp, input logic [4:0] rd);
        int stalls = 0;
        set_ex(1'b1, a, 32'h0, 1'b1, 1'b0, f3, 1'b1, rd);
        #3 if (MemStall) stalls++;
        tick();
        chk({nm, " req"}, dm.DmemReq, 1'b1);
        chk({nm, " addr"}, dm.DmemAddr, {a[31:2], 2'b00});
        chk({nm, " we"}, dm.DmemWe, 1'b0);
        chk({nm, " bubble"}, MemRegWrite, 1'b0);
        for (int i = 0; i < waits; i++) begin
            #3 if (MemStall) stalls++;
            tick();
            chk({nm, " wait rw"}, MemRegWrite, 1'b0);
        end
        dm.DmemAck = 1'b1; dm.DmemRdata = word;
        #3 if (MemStall) stalls++;
        tick();
        dm.DmemAck = 1'b0; dm.DmemRdata = 32'h0;
        idle_ex();
        chk({nm, " stall cycles"}, stalls, waits + 1);
        chk({nm, " result"}, MemResult, exp);
        chk({nm, " rw"}, MemRegWrite, 1'b1);
        chk({nm, " rd"}, MemRd, rd);
        chk({nm, " req drop"}, dm.DmemReq, 1'b0);
    endtask

    task automatic do_store(input string nm, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] sd, input logic [3:0] ebe,
                            input logic [31:0] ewd, input int waits);
        set_ex(1'b1, a, sd, 1'b0, 1'b1, f3, 1'b1, 5'd1);
        #3 chk({nm, " issue stall"}, MemStall, 1'b1);
        tick();
        for (int i = 0; i <= waits; i++) begin
            chk({nm, " we"}, dm.DmemWe, 1'b1);
            chk({nm, " be"}, dm.DmemBe, ebe);
            chk({nm, " wdata"}, dm.DmemWdata, ewd);
            chk({nm, " addr"}, dm.DmemAddr, {a[31:2], 2'b00});
            if (i == waits) dm.DmemAck = 1'b1;
            #3 chk({nm, " stall"}, MemStall, (i == waits) ? 1'b0 : 1'b1);
            tick();
        end
        dm.DmemAck = 1'b0;
        idle_ex();
        chk({nm, " rw"}, MemRegWrite, 1'b0);
        chk({nm, " req drop"}, dm.DmemReq, 1'b0);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic        rd_en, wr_en;
        logic [2:0]  f3;
        logic        rw;
        logic [4:0]  rd;
        logic        chk_res;
        logic [31:0] e_res;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  f3;
        logic [31:0] word;
        int          waits;
        logic [31:0] exp;
    } ld_t;

    vec_t vt[9];
    ld_t  lt[9];

    initial begin
        vt[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5,  1'b1, 32'h0000_1234, 1'b1, 5'd5,  1'b0};
        vt[1] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'b000, 1'b1, 5'd7,  1'b1, 32'hDEAD_BEEF, 1'b0, 5'd7,  1'b0};
        vt[2] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b000, 1'b0, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd31, 1'b0};
        vt[3] = '{1'b1, 32'h0000_0006, 1'b1, 1'b0, 3'b010, 1'b1, 5'd2,  1'b0, 32'h0,         1'b0, 5'd0,  1'b1};
        vt[4] = '{1'b1, 32'h0000_0101, 1'b1, 1'b0, 3'b001, 1'b1, 5'd3,  1'b0, 32'h0,         1'b0, 5'd0,  1'b1};
        vt[5] = '{1'b1, 32'h0000_0002, 1'b0, 1'b1, 3'b010, 1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 5'd0,  1'b1};
        vt[6] = '{1'b1, 32'h0000_0013, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 5'd0,  1'b1};
        vt[7] = '{1'b1, 32'h0000_0002, 1'b1, 1'b0, 3'b011, 1'b1, 5'd4,  1'b0, 32'h0,         1'b0, 5'd0,  1'b1};
        vt[8] = '{1'b1, 32'h0000_5A5A, 1'b0, 1'b0, 3'b000, 1'b1, 5'd9,  1'b1, 32'h0000_5A5A, 1'b1, 5'd9,  1'b0};

        lt[0] = '{32'h103, 3'b000, 32'h80FF_0011, 2, 32'hFFFF_FF80};
        lt[1] = '{32'h103, 3'b100, 32'h80FF_0011, 0, 32'h0000_0080};
        lt[2] = '{32'h102, 3'b000, 32'h80FF_0011, 0, 32'hFFFF_FFFF};
        lt[3] = '{32'h102, 3'b100, 32'h80FF_0011, 1, 32'h0000_00FF};
        lt[4] = '{32'h102, 3'b001, 32'h80FF_0011, 0, 32'hFFFF_80FF};
        lt[5] = '{32'h102, 3'b101, 32'h80FF_0011, 0, 32'h0000_80FF};
        lt[6] = '{32'h100, 3'b001, 32'h80FF_0011, 0, 32'h0000_0011};
        lt[7] = '{32'h104, 3'b010, 32'h1234_5678, 3, 32'h1234_5678};
        lt[8] = '{32'h108, 3'b111, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5};

        idle_ex();
        dm.DmemAck = 1'b0; dm.DmemRdata = 32'h0;
        tick();
        tick();
        chk("rst MemResult", MemResult, 32'h0);
        chk("rst MemRegWrite", MemRegWrite, 1'b0);
        chk("rst MemRd", MemRd, 5'd0);
        chk("rst DmemReq", dm.DmemReq, 1'b0);
        chk("rst DmemWe", dm.DmemWe, 1'b0);
        chk("rst DmemAddr", dm.DmemAddr, 32'h0);
        chk("rst DmemWdata", dm.DmemWdata, 32'h0);
        chk("rst DmemBe", dm.DmemBe, 4'h0);
        chk("rst MemMisalign", MemMisalign, 1'b0);
`ifdef MEM_TIMEOUT_EN
        chk("rst MemTimeout", MemTimeout, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            set_ex(vt[i].v, vt[i].alu, 32'h0, vt[i].rd_en, vt[i].wr_en, vt[i].f3, vt[i].rw, vt[i].rd);
            #3 chk($sformatf("vec%0d stall", i), MemStall, 1'b0);
            tick();
            chk($sformatf("vec%0d req", i), dm.DmemReq, 1'b0);
            chk($sformatf("vec%0d rw", i), MemRegWrite, vt[i].e_rw);
            chk($sformatf("vec%0d misalign", i), MemMisalign, vt[i].e_mis);
            if (vt[i].chk_res) begin
                chk($sformatf("vec%0d result", i), MemResult, vt[i].e_res);
                chk($sformatf("vec%0d rd", i), MemRd, vt[i].e_rd);
            end
        end

        foreach (lt[i])
            do_load($sformatf("load%0d", i), lt[i].a, lt[i].f3, lt[i].word, lt[i].waits, lt[i].exp, 5'(i + 10));

        do_store("sh22", 32'h22, 3'b001, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 1);
        do_store("sb41", 32'h41, 3'b000, 32'h1234_5678, 4'b0010, 32'h7878_7878, 0);
        do_store("sw80", 32'h80, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 2);
        do_store("sh10", 32'h10, 3'b001, 32'hFFFF_1234, 4'b0011, 32'h1234_1234, 0);

        // Ack while idle must not disturb an ALU op.
        set_ex(1'b1, 32'h0000_55AA, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd4);
        dm.DmemAck = 1'b1; dm.DmemRdata = 32'hFFFF_0000;
        #3 chk("idle ack stall", MemStall, 1'b0);
        tick();
        dm.DmemAck = 1'b0;
        chk("idle ack result", MemResult, 32'h0000_55AA);
        chk("idle ack rw", MemRegWrite, 1'b1);
        chk("idle ack req", dm.DmemReq, 1'b0);

        // Asynchronous reset in ACCESS, then a stray ack.
        set_ex(1'b1, 32'h200, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd3);
        tick();
        chk("rstacc req before", dm.DmemReq, 1'b1);
        idle_ex();
        #2 rst_n = 1'b0;
        #1;
        chk("rstacc req", dm.DmemReq, 1'b0);
        chk("rstacc result", MemResult, 32'h0);
        chk("rstacc rw", MemRegWrite, 1'b0);
        chk("rstacc addr", dm.DmemAddr, 32'h0);
        chk("rstacc be", dm.DmemBe, 4'h0);
        tick();
        rst_n = 1'b1;
        dm.DmemAck = 1'b1; dm.DmemRdata = 32'hFFFF_FFFF;
        #3 chk("stray ack stall", MemStall, 1'b0);
        tick();
        dm.DmemAck = 1'b0;
        chk("stray ack req", dm.DmemReq, 1'b0);
        chk("stray ack rw", MemRegWrite, 1'b0);
        chk("stray ack result", MemResult, 32'h0);

`ifdef MEM_TIMEOUT_EN
        begin
            int stalls = 0;
            set_ex(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd6);
            #3 if (MemStall) stalls++;
            tick();
            idle_ex();
            for (int i = 1; i <= 4; i++) begin
                chk("timeout req held", dm.DmemReq, 1'b1);
                #3 if (MemStall) stalls++;
                if (i == 4) chk("timeout cycle stall", MemStall, 1'b0);
                tick();
            end
            chk("timeout stall cycles", stalls, 4);
            chk("timeout pulse", MemTimeout, 1'b1);
            chk("timeout req", dm.DmemReq, 1'b0);
            chk("timeout rw", MemRegWrite, 1'b0);
            tick();
            chk("timeout pulse end", MemTimeout, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end
endmodule
